coef_t_bank: RTL and testbench

- Parametrised successor to the single-x Chebyshev T(k) coefficient ROM.
- Stores T(k)_x(j) words for NUM_X sample points in one loadable register bank.
- Serves single-word reads or full-row bursts to the systolic filter array over a valid/ready output handshake.
- Sits between the coefficient loader (load port) and the first systolic PE (read port).

---
 rtl/coef_t_bank.sv | 171 +++++++++++++++++
 tb/tb_coef_t_bank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/coef_t_bank.sv
// Loadable bank of Chebyshev T(k) coefficients for NUM_X sample points, read as single words or
// full-row bursts over a valid/ready handshake. Optional macro COEF_TRISTATE_EN tristates o_rom_data.
module coef_t_bank #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int NUM_X  = 8,
   parameter int X_W    = 3
) (
   input  logic              c_clk,
   input  logic              c_rst_n,
   input  logic              c_rom_ce,
   input  logic              c_rom_tri_output,
   input  logic              c_load_en,
   input  logic [X_W-1:0]    i_load_x,
   input  logic [ADDR_W-1:0] i_load_addr,
   input  logic [DATA_W-1:0] i_load_data,
   input  logic              c_rd_req,
   input  logic              c_burst,
   input  logic [X_W-1:0]    i_x_sel,
   input  logic [ADDR_W-1:0] i_rom_address,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_rom_data,
   output logic              o_valid,
   output logic              o_last,
   output logic              o_busy,
   output logic              o_err
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int XI_W  = (NUM_X > 1) ? $clog2(NUM_X) : 1;
   localparam logic [X_W:0]      NUM_X_L   = (X_W + 1)'(NUM_X);
   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_READ = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [XI_W-1:0]     x_q, x_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                burst_q, burst_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   bank_q [NUM_X][DEPTH];
   logic [DATA_W-1:0]   bank_d [NUM_X][DEPTH];

   logic                rd_x_ok_s, ld_x_ok_s, rd_go_s;
   logic [XI_W-1:0]     rd_x_s, ld_x_s;
   logic [ADDR_W-1:0]   start_addr_s, next_addr_s;

   assign rd_x_ok_s    = ({1'b0, i_x_sel} < NUM_X_L);
   assign ld_x_ok_s    = ({1'b0, i_load_x} < NUM_X_L);
   assign rd_x_s       = i_x_sel[XI_W-1:0];
   assign ld_x_s       = i_load_x[XI_W-1:0];
   assign start_addr_s = c_burst ? {ADDR_W{1'b0}} : i_rom_address;
   assign next_addr_s  = addr_q + ADDR_W'(1);
   assign rd_go_s      = (state_q == ST_IDLE) && c_rd_req && c_rom_ce && rd_x_ok_s;

   // Next-state, bank write and output-register computation.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      addr_d  = addr_q;
      burst_d = burst_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      bank_d  = bank_q;
      // Out-of-range x flags only requests that would otherwise have been accepted.
      err_d   = err_q
              | (c_load_en & ~ld_x_ok_s)
              | ((state_q == ST_IDLE) & c_rd_req & c_rom_ce & ~rd_x_ok_s);

      if (c_load_en && ld_x_ok_s) begin
         bank_d[ld_x_s][i_load_addr] = i_load_data;
      end else begin
         bank_d = bank_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (rd_go_s) begin
               state_d = ST_READ;
               x_d     = rd_x_s;
               addr_d  = start_addr_s;
               burst_d = c_burst;
               data_d  = bank_q[rd_x_s][start_addr_s];
               valid_d = 1'b1;
               last_d  = !c_burst || (start_addr_s == LAST_ADDR);
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (!c_rom_ce) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               last_d  = 1'b0;
               busy_d  = 1'b0;
            end else if (valid_q && i_ready) begin
               if (last_q) begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  addr_d  = next_addr_s;
                  data_d  = bank_q[x_q][next_addr_s];
                  last_d  = (next_addr_s == LAST_ADDR);
               end
            end else begin
               state_d = ST_READ;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, bank and output registers.
   always_ff @(posedge c_clk or negedge c_rst_n) begin
      if (!c_rst_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         addr_q  <= '0;
         burst_q <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < NUM_X; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               bank_q[i][j] <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         addr_q  <= addr_d;
         burst_q <= burst_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         bank_q  <= bank_d;
      end
   end

   assign o_valid = valid_q;
   assign o_last  = last_q;
   assign o_busy  = busy_q;
   assign o_err   = err_q;

`ifdef COEF_TRISTATE_EN
   assign o_rom_data = (c_rom_tri_output || !c_rom_ce) ? {DATA_W{1'bz}} : data_q;
`else
   logic unused_tri_s;
   assign unused_tri_s = c_rom_tri_output;
   assign o_rom_data   = data_q;
`endif

endmodule

// File: tb/tb_coef_t_bank.sv
// Scoreboard bench for coef_t_bank: stimulus pushes expected {last,data} beats, a negedge
// monitor pops them on every handshake transfer. Tristate checks are built with COEF_TRISTATE_EN.
module tb_coef_t_bank;

   logic        c_clk = 1'b0;
   logic        c_rst_n, c_rom_ce, c_rom_tri_output, c_load_en;
   logic [3:0]  i_load_x;
   logic [2:0]  i_load_addr;
   logic [15:0] i_load_data;
   logic        c_rd_req, c_burst;
   logic [3:0]  i_x_sel;
   logic [2:0]  i_rom_address;
   logic        i_ready;
   logic [15:0] o_rom_data;
   logic        o_valid, o_last, o_busy, o_err;

   int n_chk  = 0;
   int n_fail = 0;
   logic [16:0] sb[$];
   logic [15:0] row5 [8];

   coef_t_bank #(.DATA_W(16), .ADDR_W(3), .NUM_X(8), .X_W(4)) dut (
      .c_clk(c_clk), .c_rst_n(c_rst_n), .c_rom_ce(c_rom_ce),
      .c_rom_tri_output(c_rom_tri_output), .c_load_en(c_load_en),
      .i_load_x(i_load_x), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
      .c_rd_req(c_rd_req), .c_burst(c_burst), .i_x_sel(i_x_sel),
      .i_rom_address(i_rom_address), .i_ready(i_ready), .o_rom_data(o_rom_data),
      .o_valid(o_valid), .o_last(o_last), .o_busy(o_busy), .o_err(o_err)
   );

   always #5 c_clk = ~c_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge c_clk);
      #1;
   endtask

   task automatic load(input logic [3:0] x, input logic [2:0] a, input logic [15:0] d);
      c_load_en = 1'b1; i_load_x = x; i_load_addr = a; i_load_data = d;
      tick;
      c_load_en = 1'b0;
   endtask

   task automatic rd(input logic [3:0] x, input logic [2:0] a, input logic b);
      c_rd_req = 1'b1; i_x_sel = x; i_rom_address = a; c_burst = b;
      tick;
      c_rd_req = 1'b0;
   endtask

   task automatic wait_idle;
      for (int i = 0; i < 100; i++) begin
         if (!o_busy && !o_valid) break;
         tick;
      end
      chk("idle_timeout", {31'd0, o_busy}, 32'd0);
   endtask

   task automatic push_burst(input int n);
      for (int i = 0; i < n; i++) sb.push_back({(i == 7) ? 1'b1 : 1'b0, row5[i]});
   endtask

   // Monitor: pops and compares one expected beat per handshake transfer.
   logic        hold_v = 1'b0;
   logic [16:0] hold_w = 17'd0;
   always @(negedge c_clk) begin
      if (c_rst_n) begin
         if (hold_v && o_valid) chk("hold_stable", {15'd0, o_last, o_rom_data}, {15'd0, hold_w});
         hold_v = o_valid && !i_ready && c_rom_ce;
         hold_w = {o_last, o_rom_data};
         if (o_valid && i_ready && c_rom_ce) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
               logic [16:0] e;
               e = sb.pop_front();
               chk("beat_last", {31'd0, o_last}, {31'd0, e[16]});
`ifdef COEF_TRISTATE_EN
               if (c_rom_tri_output) begin
                  n_chk++;
                  if (o_rom_data !== 16'hzzzz) begin
                     n_fail++;
                     $display("FAIL beat_tri: got %h expected zzzz", o_rom_data);
                  end
               end else begin
                  chk("beat_data", {16'd0, o_rom_data}, {16'd0, e[15:0]});
               end
`else
               chk("beat_data", {16'd0, o_rom_data}, {16'd0, e[15:0]});
`endif
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      row5 = '{16'h7FFF, 16'h2FFF, 16'hA400, 16'h8B00, 16'h043F, 16'h782F, 16'h55E3, 16'hC83B};
      c_rst_n = 1'b0; c_rom_ce = 1'b1; c_rom_tri_output = 1'b0; c_load_en = 1'b0;
      i_load_x = 4'd0; i_load_addr = 3'd0; i_load_data = 16'd0;
      c_rd_req = 1'b0; c_burst = 1'b0; i_x_sel = 4'd0; i_rom_address = 3'd0; i_ready = 1'b1;
      tick; tick;
      chk("rst_data",  {16'd0, o_rom_data}, 32'd0);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_last",  {31'd0, o_last}, 32'd0);
      chk("rst_busy",  {31'd0, o_busy}, 32'd0);
      chk("rst_err",   {31'd0, o_err}, 32'd0);
      c_rst_n = 1'b1;
      tick;

      // single read of cleared bank, first beat one cycle after request
      sb.push_back({1'b1, 16'h0000});
      rd(4'd0, 3'd0, 1'b0);
      chk("single_valid", {31'd0, o_valid}, 32'd1);
      chk("single_last",  {31'd0, o_last}, 32'd1);
      chk("single_busy",  {31'd0, o_busy}, 32'd1);
      chk("single_err",   {31'd0, o_err}, 32'd0);
      wait_idle;

      for (int i = 0; i < 8; i++) load(4'd5, 3'(i), row5[i]);

      // full burst; second request while busy must be ignored
      push_burst(8);
      rd(4'd5, 3'd0, 1'b1);
      rd(4'd0, 3'd0, 1'b0);
      wait_idle;
      chk("hold_after_burst", {16'd0, o_rom_data}, {16'd0, 16'hC83B});
      chk("valid_after_burst", {31'd0, o_valid}, 32'd0);

      // backpressure at beat 2
      push_burst(8);
      rd(4'd5, 3'd0, 1'b1);
      tick; tick;
      i_ready = 1'b0;
      tick; tick; tick;
      chk("bp_data", {16'd0, o_rom_data}, {16'd0, 16'hA400});
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      i_ready = 1'b1;
      wait_idle;

      // abort with chip enable at beat 4
      push_burst(4);
      rd(4'd5, 3'd0, 1'b1);
      tick; tick; tick; tick;
      c_rom_ce = 1'b0;
      tick;
      chk("abort_valid", {31'd0, o_valid}, 32'd0);
      chk("abort_last",  {31'd0, o_last}, 32'd0);
      chk("abort_busy",  {31'd0, o_busy}, 32'd0);
      c_rom_ce = 1'b1;
      sb.push_back({1'b1, 16'hC83B});
      rd(4'd5, 3'd7, 1'b0);
      wait_idle;

      // load and read of the same entry in one cycle: old value, then new
      sb.push_back({1'b1, 16'h8B00});
      c_load_en = 1'b1; i_load_x = 4'd5; i_load_addr = 3'd3; i_load_data = 16'h1234;
      rd(4'd5, 3'd3, 1'b0);
      c_load_en = 1'b0;
      wait_idle;
      sb.push_back({1'b1, 16'h1234});
      rd(4'd5, 3'd3, 1'b0);
      wait_idle;

      // chip enable low in idle: reads ignored, loads accepted
      c_rom_ce = 1'b0;
      rd(4'd5, 3'd0, 1'b0);
      chk("ce_idle_valid", {31'd0, o_valid}, 32'd0);
      chk("ce_idle_busy",  {31'd0, o_busy}, 32'd0);
      load(4'd5, 3'd1, 16'h0BEE);
      c_rom_ce = 1'b1;
      sb.push_back({1'b1, 16'h0BEE});
      rd(4'd5, 3'd1, 1'b0);
      wait_idle;

      // out-of-range read
      chk("err_before", {31'd0, o_err}, 32'd0);
      rd(4'd8, 3'd0, 1'b0);
      chk("oor_valid", {31'd0, o_valid}, 32'd0);
      chk("oor_busy",  {31'd0, o_busy}, 32'd0);
      chk("oor_err",   {31'd0, o_err}, 32'd1);
      sb.push_back({1'b1, 16'h7FFF});
      rd(4'd5, 3'd0, 1'b0);
      wait_idle;
      chk("err_sticky", {31'd0, o_err}, 32'd1);

      // reset clears error and bank; out-of-range load is dropped and flagged
      c_rst_n = 1'b0;
      tick;
      chk("rst2_err", {31'd0, o_err}, 32'd0);
      c_rst_n = 1'b1;
      tick;
      load(4'd9, 3'd0, 16'hBEEF);
      chk("oor_load_err", {31'd0, o_err}, 32'd1);
      sb.push_back({1'b1, 16'h0000});
      rd(4'd5, 3'd0, 1'b0);
      wait_idle;

`ifdef COEF_TRISTATE_EN
      c_rom_tri_output = 1'b1;
      sb.push_back({1'b1, 16'h0000});
      rd(4'd5, 3'd0, 1'b0);
      chk("tri_valid", {31'd0, o_valid}, 32'd1);
      wait_idle;
      chk("tri_valid_low", {31'd0, o_valid}, 32'd0);
      c_rom_tri_output = 1'b0;
`endif

      tick; tick;
      chk("sb_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
